tinyqv_instr_prefetch: RTL and testbench

// Instruction fetch stage directly upstream of the nibble-serial tiny45 core. Issues

---
 rtl/tinyqv_instr_prefetch.sv | 102 ++++++++++
 tb/tb_tinyqv_instr_prefetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch for the tiny45 core: halfword reads into a small FIFO,
// presenting a 32-bit instruction and its PC, with pop and branch-redirect handling.
module tinyqv_instr_prefetch #(
  parameter int unsigned          ADDR_BITS  = 24,
  parameter int unsigned          DEPTH_HW   = 4,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_complete,
  input  logic                 branch,
  input  logic [ADDR_BITS-1:0] branch_target,
  output logic [31:0]          instr,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 instr_valid,
  output logic                 mem_req,
  output logic [ADDR_BITS-2:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [15:0]          mem_data
);

  localparam int unsigned PTR_W = (DEPTH_HW > 1) ? $clog2(DEPTH_HW) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH_HW + 1);
  localparam logic [ADDR_BITS-1:0] RESET_PC = {RESET_ADDR[ADDR_BITS-1:1], 1'b0};

  logic [15:0]          fifo_q [DEPTH_HW];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [ADDR_BITS-1:0] fetch_addr_q, fetch_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic                 redirect, push, pop;
  logic                 unused_target_bit;

  assign unused_target_bit = branch_target[0];

  assign redirect = instr_complete && branch;
  assign push     = mem_req_q && mem_ready && !redirect;
  assign pop      = instr_complete && instr_valid && !branch;

  // Next-state for FIFO bookkeeping, PC, fetch address and request
  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    mem_req_d    = mem_req_q;
    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      pc_d         = {branch_target[ADDR_BITS-1:1], 1'b0};
      fetch_addr_d = {branch_target[ADDR_BITS-1:1], 1'b0};
      mem_req_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d     = PTR_W'(wr_ptr_q + PTR_W'(1));
        fetch_addr_d = fetch_addr_q + ADDR_BITS'(2);
      end
      if (pop) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(2));
        pc_d     = pc_q + ADDR_BITS'(4);
      end
      count_d   = count_q + CNT_W'(push) - (pop ? CNT_W'(2) : CNT_W'(0));
      mem_req_d = (count_d < CNT_W'(DEPTH_HW));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      mem_req_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      mem_req_q    <= mem_req_d;
    end
  end

  // Halfword storage; contents beyond count are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  assign instr       = {fifo_q[PTR_W'(rd_ptr_q + PTR_W'(1))], fifo_q[rd_ptr_q]};
  assign pc          = pc_q;
  assign instr_valid = (count_q >= CNT_W'(2));
  assign mem_req     = mem_req_q;
  assign mem_addr    = fetch_addr_q[ADDR_BITS-1:1];

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Directed bench for tinyqv_instr_prefetch against an address-derived memory image.
module tb_tinyqv_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_complete;
  logic        branch;
  logic [23:0] branch_target;
  logic [31:0] instr;
  logic [23:0] pc;
  logic        instr_valid;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;

  int checks = 0;
  int errors = 0;

  tinyqv_instr_prefetch #(
    .ADDR_BITS (24),
    .DEPTH_HW  (4),
    .RESET_ADDR(24'h000000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_complete(instr_complete),
    .branch        (branch),
    .branch_target (branch_target),
    .instr         (instr),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hw_of(input logic [22:0] a);
    return (a[15:0] ^ 16'hA5A5) ^ {9'b0, a[22:16]};
  endfunction

  function automatic logic [31:0] instr_of(input logic [23:0] p);
    logic [22:0] a;
    a = p[23:1];
    return {hw_of(a + 23'd1), hw_of(a)};
  endfunction

  always_comb mem_data = hw_of(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp_pc;
    logic        prev_req, prev_ready;
    logic [22:0] prev_addr;
    int          pops;

    rst = 1'b1; instr_complete = 1'b0; branch = 1'b0;
    branch_target = '0; mem_ready = 1'b1;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);

    // Fill from reset with zero-wait memory
    rst = 1'b0;
    step();
    chk("fill_req", 32'(mem_req), 32'd1);
    chk("fill_addr0", 32'(mem_addr), 32'd0);
    step();
    chk("fill_addr1", 32'(mem_addr), 32'd1);
    chk("fill_valid_1hw", 32'(instr_valid), 32'd0);
    step();
    chk("fill_addr2", 32'(mem_addr), 32'd2);
    chk("fill_valid", 32'(instr_valid), 32'd1);
    chk("fill_instr", instr, instr_of(24'h0));
    chk("fill_pc", 32'(pc), 32'd0);
    step();
    chk("fill_addr3", 32'(mem_addr), 32'd3);
    step();
    chk("full_req_drop", 32'(mem_req), 32'd0);
    step();
    chk("full_req_hold", 32'(mem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);

    // Continuous pops with zero-wait memory
    exp_pc = 24'h0;
    pops = 0;
    instr_complete = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (instr_valid) begin
        chk("stream_pc", 32'(pc), 32'(exp_pc));
        chk("stream_instr", instr, instr_of(exp_pc));
        exp_pc = exp_pc + 24'd4;
        pops++;
      end
      step();
    end
    instr_complete = 1'b0;
    chk("stream_progress", 32'(pops >= 8), 32'd1);

    // Redirect while a read is being accepted in the same cycle
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("br_req_pending", 32'(mem_req), 32'd1);
    instr_complete = 1'b1; branch = 1'b1; branch_target = 24'h000102;
    step();
    instr_complete = 1'b0; branch = 1'b0;
    chk("br_req_drop", 32'(mem_req), 32'd0);
    chk("br_pc", 32'(pc), 32'h102);
    chk("br_valid", 32'(instr_valid), 32'd0);
    step();
    chk("br_req", 32'(mem_req), 32'd1);
    chk("br_addr", 32'(mem_addr), 32'h81);
    step(); step();
    chk("br_valid2", 32'(instr_valid), 32'd1);
    chk("br_instr", instr, instr_of(24'h102));
    chk("br_pc2", 32'(pc), 32'h102);

    // Random memory stalls and random pops from the unaligned stream
    exp_pc = 24'h102;
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      if (instr_valid) begin
        chk("rnd_pc", 32'(pc), 32'(exp_pc));
        chk("rnd_instr", instr, instr_of(exp_pc));
      end
      if (i > 0 && prev_req && !prev_ready) begin
        chk("rnd_req_hold", 32'(mem_req), 32'd1);
        chk("rnd_addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      instr_complete = ($urandom_range(0, 1) == 1);
      mem_ready = ($urandom_range(0, 9) < 3);
      if (instr_complete && instr_valid) begin
        exp_pc = exp_pc + 24'd4;
        pops++;
      end
      prev_req = mem_req; prev_ready = mem_ready; prev_addr = mem_addr;
      step();
    end
    chk("rnd_progress", 32'(pops >= 10), 32'd1);

    // Reset in the middle of a fill
    mem_ready = 1'b1;
    instr_complete = 1'b1; branch = 1'b1; branch_target = 24'h000200;
    step();
    instr_complete = 1'b0; branch = 1'b0;
    step(); step(); step(); step();
    chk("mid_valid_cnt3", 32'(instr_valid), 32'd1);
    chk("mid_req_cnt3", 32'(mem_req), 32'd1);
    chk("mid_pc", 32'(pc), 32'h200);
    rst = 1'b1;
    step();
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    rst = 1'b0; branch = 1'b1; branch_target = 24'h000300;
    step();
    chk("refetch_pc_no_ic", 32'(pc), 32'd0);
    chk("refetch_req", 32'(mem_req), 32'd1);
    chk("refetch_addr", 32'(mem_addr), 32'd0);
    branch = 1'b0; instr_complete = 1'b1;
    step();
    chk("refetch_valid_1hw", 32'(instr_valid), 32'd0);
    step();
    instr_complete = 1'b0;
    chk("refetch_valid", 32'(instr_valid), 32'd1);
    chk("refetch_pc", 32'(pc), 32'd0);
    chk("refetch_instr", instr, instr_of(24'h0));

    // Address wrap at the top of the space
    instr_complete = 1'b1; branch = 1'b1; branch_target = 24'hFFFFFC;
    step();
    instr_complete = 1'b0; branch = 1'b0;
    chk("wrap_pc", 32'(pc), 32'hFFFFFC);
    step();
    chk("wrap_addr_a", 32'(mem_addr), 32'h7FFFFE);
    step(); step();
    chk("wrap_addr_zero", 32'(mem_addr), 32'd0);
    chk("wrap_valid", 32'(instr_valid), 32'd1);
    chk("wrap_instr", instr, instr_of(24'hFFFFFC));
    instr_complete = 1'b1;
    step();
    instr_complete = 1'b0;
    chk("wrap_pc_zero", 32'(pc), 32'd0);
    step();
    chk("wrap_valid2", 32'(instr_valid), 32'd1);
    chk("wrap_instr2", instr, instr_of(24'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
